// File: rtl/mna_flit_injector.sv
// MNA flit injector: serializes one captured header/body/tail packet onto the NoC
// injection link, one flit per cycle, gated by per-VC credit counters.
module mna_flit_injector #(
  parameter int VC_DEPTH = 4,
  parameter int CREDIT_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        awrite,
  input  logic [36:0] header,
  input  logic [36:0] body,
  input  logic [36:0] tail,
  input  logic [7:0]  credit_in,
  output logic [36:0] flit_out,
  output logic        flit_valid,
  output logic        pkt_sent
);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(VC_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_HEAD = 2'd1,
    SEND_BODY = 2'd2,
    SEND_TAIL = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [36:0]        hdr_q, hdr_d;
  logic [36:0]        body_q, body_d;
  logic [36:0]        tail_q, tail_d;
  logic               write_q, write_d;
  logic [2:0]         vc_q, vc_d;
  logic [36:0]        flit_out_q, flit_out_d;
  logic               flit_valid_q, flit_valid_d;
  logic               pkt_sent_q, pkt_sent_d;
  logic [CREDIT_W-1:0] credit_q [8];
  logic [CREDIT_W-1:0] credit_d [8];
  logic               fire_s;

  // A send state fires only on the registered count of its VC.
  assign fire_s = (state_q != IDLE) && (credit_q[vc_q] != '0);

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    body_d       = body_q;
    tail_d       = tail_q;
    write_d      = write_q;
    vc_d         = vc_q;
    flit_out_d   = flit_out_q;
    flit_valid_d = 1'b0;
    pkt_sent_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          hdr_d   = header;
          body_d  = body;
          tail_d  = tail;
          write_d = awrite;
          vc_d    = header[34:32];
          state_d = SEND_HEAD;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_HEAD: begin
        if (fire_s) begin
          flit_out_d   = hdr_q;
          flit_valid_d = 1'b1;
          state_d      = write_q ? SEND_BODY : SEND_TAIL;
        end else begin
          state_d = SEND_HEAD;
        end
      end
      SEND_BODY: begin
        if (fire_s) begin
          flit_out_d   = body_q;
          flit_valid_d = 1'b1;
          state_d      = SEND_TAIL;
        end else begin
          state_d = SEND_BODY;
        end
      end
      SEND_TAIL: begin
        if (fire_s) begin
          flit_out_d   = tail_q;
          flit_valid_d = 1'b1;
          pkt_sent_d   = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = SEND_TAIL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Simultaneous fire and return cancel out; returns saturate at VC_DEPTH.
  always_comb begin
    for (int v = 0; v < 8; v++) begin
      credit_d[v] = credit_q[v];
      if (fire_s && (vc_q == 3'(v)) && !credit_in[v]) begin
        credit_d[v] = credit_q[v] - {{(CREDIT_W-1){1'b0}}, 1'b1};
      end else if (!(fire_s && (vc_q == 3'(v))) && credit_in[v] && (credit_q[v] != CREDIT_MAX)) begin
        credit_d[v] = credit_q[v] + {{(CREDIT_W-1){1'b0}}, 1'b1};
      end else begin
        credit_d[v] = credit_q[v];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hdr_q        <= 37'd0;
      body_q       <= 37'd0;
      tail_q       <= 37'd0;
      write_q      <= 1'b0;
      vc_q         <= 3'd0;
      flit_out_q   <= 37'd0;
      flit_valid_q <= 1'b0;
      pkt_sent_q   <= 1'b0;
      for (int v = 0; v < 8; v++) begin
        credit_q[v] <= CREDIT_MAX;
      end
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      body_q       <= body_d;
      tail_q       <= tail_d;
      write_q      <= write_d;
      vc_q         <= vc_d;
      flit_out_q   <= flit_out_d;
      flit_valid_q <= flit_valid_d;
      pkt_sent_q   <= pkt_sent_d;
      for (int v = 0; v < 8; v++) begin
        credit_q[v] <= credit_d[v];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign flit_out   = flit_out_q;
  assign flit_valid = flit_valid_q;
  assign pkt_sent   = pkt_sent_q;

endmodule

// File: tb/tb_mna_flit_injector.sv
// Self-checking bench for mna_flit_injector: scoreboard of expected flits plus
// per-scenario cycle checks of valid/ready/pkt_sent and credit behaviour.
module tb_mna_flit_injector;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        awrite;
  logic [36:0] header;
  logic [36:0] body;
  logic [36:0] tail;
  logic [7:0]  credit_in;
  logic [36:0] flit_out;
  logic        flit_valid;
  logic        pkt_sent;

  int          passed;
  int          total;
  logic [36:0] exp_q [$];
  logic [36:0] exp_f;

  mna_flit_injector #(.VC_DEPTH(4), .CREDIT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .awrite(awrite), .header(header), .body(body), .tail(tail),
    .credit_in(credit_in), .flit_out(flit_out), .flit_valid(flit_valid),
    .pkt_sent(pkt_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard: every issued flit must match the next expected flit in order.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && flit_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL flit_unexpected: got %h, expected no flit", flit_out);
      end else begin
        exp_f = exp_q.pop_front();
        if (flit_out !== exp_f) $display("FAIL flit_content: got %h, expected %h", flit_out, exp_f);
        else passed++;
      end
    end
  end

  function automatic logic [36:0] mk_hdr(input logic [2:0] vc, input logic [3:0] dst,
                                         input logic [3:0] src, input logic rd);
    mk_hdr = {2'b10, vc, dst, src, 23'd0, rd};
  endfunction

  function automatic logic [36:0] mk_body(input logic [31:0] d);
    mk_body = {2'b00, 3'd0, d};
  endfunction

  function automatic logic [36:0] mk_tail(input logic [31:0] d);
    mk_tail = {2'b01, 3'd0, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic aw, input logic [36:0] h, input logic [36:0] b,
                          input logic [36:0] t);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (req_ready !== 1'b1) begin
      total++;
      $display("FAIL send_wait_ready: got %b, expected 1 within 20 cycles", req_ready);
    end
    awrite    = aw;
    header    = h;
    body      = b;
    tail      = t;
    req_valid = 1'b1;
    exp_q.push_back(h);
    if (aw) exp_q.push_back(b);
    exp_q.push_back(t);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic count_flits(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (flit_valid === 1'b1) n++;
    end
  endtask

  task automatic restore_credits(input int vc);
    credit_in[vc] = 1'b1;
    repeat (4) tick();
    credit_in[vc] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; awrite = 1'b0; credit_in = 8'd0;
    header = 37'd0; body = 37'd0; tail = 37'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b, expected 1", req_ready); else passed++;
    total++; if (flit_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", flit_valid); else passed++;
    total++; if (pkt_sent !== 1'b0) $display("FAIL reset_pkt_sent: got %b, expected 0", pkt_sent); else passed++;
    total++; if (flit_out !== 37'd0) $display("FAIL reset_flit_out: got %h, expected 0", flit_out); else passed++;
  endtask

  task automatic test_write();
    int n;
    send_pkt(1'b1, mk_hdr(3'b010, 4'h3, 4'h1, 1'b0), mk_body(32'h1000_0004), mk_tail(32'hDEAD_BEEF));
    tick();
    total++; if (flit_valid !== 1'b1 || flit_out[36:35] !== 2'b10 || req_ready !== 1'b0)
      $display("FAIL wr_head: got v=%b type=%b rdy=%b, expected v=1 type=10 rdy=0", flit_valid, flit_out[36:35], req_ready); else passed++;
    tick();
    total++; if (flit_valid !== 1'b1 || flit_out[36:35] !== 2'b00)
      $display("FAIL wr_body: got v=%b type=%b, expected v=1 type=00", flit_valid, flit_out[36:35]); else passed++;
    tick();
    total++; if (flit_valid !== 1'b1 || flit_out[36:35] !== 2'b01 || pkt_sent !== 1'b1 || req_ready !== 1'b1)
      $display("FAIL wr_tail: got v=%b type=%b ps=%b rdy=%b, expected 1 01 1 1", flit_valid, flit_out[36:35], pkt_sent, req_ready); else passed++;
    tick();
    total++; if (flit_valid !== 1'b0 || pkt_sent !== 1'b0)
      $display("FAIL wr_after: got v=%b ps=%b, expected 0 0", flit_valid, pkt_sent); else passed++;
    // One credit left on VC 2: a read issues its header and stalls on the tail.
    send_pkt(1'b0, mk_hdr(3'b010, 4'h3, 4'h1, 1'b1), 37'd0, mk_tail(32'h0000_0040));
    count_flits(4, n);
    total++; if (n !== 1) $display("FAIL wr_credit_left: got %0d flits, expected 1", n); else passed++;
    credit_in[2] = 1'b1;
    tick();
    credit_in[2] = 1'b0;
    total++; if (flit_valid !== 1'b0) $display("FAIL wr_credit_edge: got %b, expected 0", flit_valid); else passed++;
    tick();
    total++; if (flit_valid !== 1'b1 || pkt_sent !== 1'b1)
      $display("FAIL wr_credit_resume: got v=%b ps=%b, expected 1 1", flit_valid, pkt_sent); else passed++;
    restore_credits(2);
  endtask

  task automatic test_read();
    int n;
    send_pkt(1'b0, mk_hdr(3'b000, 4'h5, 4'h2, 1'b1), mk_body(32'hFFFF_FFFF), mk_tail(32'h0000_1230));
    tick();
    total++; if (flit_valid !== 1'b1 || flit_out[36:35] !== 2'b10 || flit_out[0] !== 1'b1)
      $display("FAIL rd_head: got v=%b type=%b rd=%b, expected 1 10 1", flit_valid, flit_out[36:35], flit_out[0]); else passed++;
    tick();
    total++; if (flit_valid !== 1'b1 || flit_out[36:35] !== 2'b01 || pkt_sent !== 1'b1)
      $display("FAIL rd_tail: got v=%b type=%b ps=%b, expected 1 01 1", flit_valid, flit_out[36:35], pkt_sent); else passed++;
    tick();
    total++; if (flit_valid !== 1'b0) $display("FAIL rd_no_body: got %b, expected 0", flit_valid); else passed++;
    // Two credits left on VC 0: a write issues header and body, then stalls.
    send_pkt(1'b1, mk_hdr(3'b000, 4'h5, 4'h2, 1'b0), mk_body(32'h0BAD_F00D), mk_tail(32'h0000_1234));
    count_flits(4, n);
    total++; if (n !== 2) $display("FAIL rd_credit_left: got %0d flits, expected 2", n); else passed++;
    credit_in[0] = 1'b1;
    tick();
    credit_in[0] = 1'b0;
    tick();
    total++; if (flit_valid !== 1'b1 || pkt_sent !== 1'b1)
      $display("FAIL rd_credit_resume: got v=%b ps=%b, expected 1 1", flit_valid, pkt_sent); else passed++;
    restore_credits(0);
  endtask

  task automatic test_back_to_back_stall();
    logic [11:0] cr;
    logic [11:0] rv;
    logic [11:0] ev;
    logic [11:0] er;
    logic [11:0] ep;
    cr = 12'b001001000000;
    rv = 12'b000000001111;
    ev = 12'b010010010111;
    er = 12'b110000000100;
    ep = 12'b010000000100;
    send_pkt(1'b1, mk_hdr(3'b101, 4'h7, 4'h0, 1'b0), mk_body(32'hA5A5_0001), mk_tail(32'h5A5A_0002));
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        header = mk_hdr(3'b101, 4'h8, 4'h0, 1'b0);
        body   = mk_body(32'hB0B0_0003);
        tail   = mk_tail(32'hC0C0_0004);
        awrite = 1'b1;
        exp_q.push_back(header);
        exp_q.push_back(body);
        exp_q.push_back(tail);
      end
      req_valid    = rv[i];
      credit_in[5] = cr[i];
      tick();
      total++;
      if (flit_valid !== ev[i] || req_ready !== er[i] || pkt_sent !== ep[i])
        $display("FAIL b2b_step%0d: got v=%b rdy=%b ps=%b, expected v=%b rdy=%b ps=%b",
                 i + 1, flit_valid, req_ready, pkt_sent, ev[i], er[i], ep[i]);
      else passed++;
    end
    credit_in[5] = 1'b0;
    restore_credits(5);
  endtask

  task automatic test_saturate();
    int n;
    credit_in[1] = 1'b1;
    repeat (6) tick();
    send_pkt(1'b1, mk_hdr(3'b001, 4'h2, 4'h4, 1'b0), mk_body(32'h1111_2222), mk_tail(32'h3333_4444));
    count_flits(4, n);
    total++; if (n !== 3) $display("FAIL sat_write_held: got %0d flits, expected 3", n); else passed++;
    credit_in[1] = 1'b0;
    tick();
    send_pkt(1'b1, mk_hdr(3'b001, 4'h2, 4'h4, 1'b0), mk_body(32'h5555_6666), mk_tail(32'h7777_8888));
    count_flits(4, n);
    total++; if (n !== 3) $display("FAIL sat_write_full: got %0d flits, expected 3", n); else passed++;
    send_pkt(1'b0, mk_hdr(3'b001, 4'h2, 4'h4, 1'b1), 37'd0, mk_tail(32'h0000_0100));
    count_flits(4, n);
    total++; if (n !== 1) $display("FAIL sat_no_overflow: got %0d flits, expected 1", n); else passed++;
    credit_in[1] = 1'b1;
    tick();
    credit_in[1] = 1'b0;
    tick();
    total++; if (flit_valid !== 1'b1 || pkt_sent !== 1'b1)
      $display("FAIL sat_resume: got v=%b ps=%b, expected 1 1", flit_valid, pkt_sent); else passed++;
    restore_credits(1);
  endtask

  task automatic test_reset_mid();
    int n;
    send_pkt(1'b1, mk_hdr(3'b011, 4'h9, 4'h6, 1'b0), mk_body(32'hCAFE_0001), mk_tail(32'hCAFE_0002));
    tick();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    total++; if (flit_valid !== 1'b0 || pkt_sent !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL rst_mid_async: got v=%b ps=%b rdy=%b, expected 0 0 1", flit_valid, pkt_sent, req_ready); else passed++;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    count_flits(4, n);
    total++; if (n !== 0) $display("FAIL rst_mid_no_tail: got %0d flits, expected 0", n); else passed++;
    send_pkt(1'b1, mk_hdr(3'b011, 4'h9, 4'h6, 1'b0), mk_body(32'hCAFE_0003), mk_tail(32'hCAFE_0004));
    count_flits(4, n);
    total++; if (n !== 3) $display("FAIL rst_mid_write: got %0d flits, expected 3", n); else passed++;
    send_pkt(1'b0, mk_hdr(3'b011, 4'h9, 4'h6, 1'b1), 37'd0, mk_tail(32'h0000_0200));
    count_flits(3, n);
    total++; if (n !== 1) $display("FAIL rst_mid_credits: got %0d flits, expected 1", n); else passed++;
    credit_in[3] = 1'b1;
    tick();
    credit_in[3] = 1'b0;
    tick();
    total++; if (flit_valid !== 1'b1 || pkt_sent !== 1'b1)
      $display("FAIL rst_mid_resume: got v=%b ps=%b, expected 1 1", flit_valid, pkt_sent); else passed++;
    restore_credits(3);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back_stall();
    test_saturate();
    test_reset_mid();
    repeat (3) tick();
    total++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending flits, expected 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
